d_sram_bridge: RTL and testbench

- Responder side of the data-memory port that the pipeline datapath drives: sig_en, byte-write strobes, byte address, write data; returns read data and d_stall.
- Converts each single-cycle sram-style access into one split-handshake bus transaction (req/addr_ok/data_ok) toward the AXI-side arbiter.
- Holds d_stall high until that transaction completes.
- Holds the returned data stable until the global longest_stall releases, so a held pipeline never re-issues the same access.

---
 rtl/d_sram_bridge_pkg.sv | 22 ++
 rtl/d_sram_size_map.sv | 25 ++
 rtl/d_sram_bridge.sv | 88 ++++++++
 tb/tb_d_sram_bridge.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/d_sram_bridge_pkg.sv
// rtl/d_sram_bridge_pkg.sv - shared encodings for the data-side sram-to-bus bridge
package d_sram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } bridgeState_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Clears the segment bits of kseg0/kseg1 addresses to reach physical space.
    localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

    function automatic logic isKseg01(input logic [31:0] a);
        return (a[31:29] == 3'b100) || (a[31:29] == 3'b101);
    endfunction

endpackage

// File: rtl/d_sram_size_map.sv
// rtl/d_sram_size_map.sv - byte strobes and core address to bus direction, size and address
module d_sram_size_map
    import d_sram_bridge_pkg::*;
#(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic [3:0]  byteStrobe,
    input  logic [31:0] coreAddr,
    output logic        isWrite,
    output logic [1:0]  size,
    output logic [31:0] busAddr
);

    always_comb begin
        isWrite = |byteStrobe;
        // Unsupported strobe patterns fall back to a word write so the bus still completes.
        case (byteStrobe)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_B;
            4'b0011, 4'b1100:                   size = SIZE_H;
            default:                            size = SIZE_W;
        endcase
        busAddr = (MAP_KSEG && isKseg01(coreAddr)) ? (coreAddr & KSEG_MASK) : coreAddr;
    end

endmodule

// File: rtl/d_sram_bridge.sv
// rtl/d_sram_bridge.sv - single-cycle sram data port to split-handshake bus bridge
module d_sram_bridge
    import d_sram_bridge_pkg::*;
#(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_en,
    input  logic [3:0]  sig_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        d_stall,
    input  logic        longest_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    bridgeState_t state;
    logic         mapWr;
    logic [1:0]   mapSize;
    logic [31:0]  mapAddr;

    d_sram_size_map #(.MAP_KSEG(MAP_KSEG)) sizeMap (
        .byteStrobe (sig_write),
        .coreAddr   (addr),
        .isWrite    (mapWr),
        .size       (mapSize),
        .busAddr    (mapAddr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rdata      <= 32'd0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= 32'd0;
            data_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (sig_en) begin
                        state      <= REQ;
                        data_req   <= 1'b1;
                        data_wr    <= mapWr;
                        data_size  <= mapSize;
                        data_addr  <= mapAddr;
                        data_wdata <= wdata;
                    end
                end
                REQ: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (data_data_ok) begin
                            state <= DONE;
                            if (!data_wr) rdata <= data_rdata;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (data_data_ok) begin
                        state <= DONE;
                        if (!data_wr) rdata <= data_rdata;
                    end
                end
                // Park here while the rest of the pipeline is frozen so the held access is not replayed.
                DONE: begin
                    if (!longest_stall) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign d_stall = ((state == IDLE) && sig_en) || (state == REQ) || (state == WAIT);

endmodule

// File: tb/tb_d_sram_bridge.sv
// tb/tb_d_sram_bridge.sv - directed and randomized checks of d_sram_bridge against a transaction model
module tb_d_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_en;
    logic [3:0]  sig_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        longest_stall;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic [31:0] rdata, data_addr, data_wdata;
    logic        d_stall, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] rdataN, data_addrN, data_wdataN;
    logic        d_stallN, data_reqN, data_wrN;
    logic [1:0]  data_sizeN;

    int          nAssert = 0;
    int          nFail = 0;
    logic [31:0] expRdata = 32'd0;

    always #5 clk = ~clk;

    d_sram_bridge #(.MAP_KSEG(1'b1)) dut (
        .clk(clk), .rst(rst), .sig_en(sig_en), .sig_write(sig_write), .addr(addr),
        .wdata(wdata), .rdata(rdata), .d_stall(d_stall), .longest_stall(longest_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    d_sram_bridge #(.MAP_KSEG(1'b0)) dutNoMap (
        .clk(clk), .rst(rst), .sig_en(sig_en), .sig_write(sig_write), .addr(addr),
        .wdata(wdata), .rdata(rdataN), .d_stall(d_stallN), .longest_stall(longest_stall),
        .data_req(data_reqN), .data_wr(data_wrN), .data_size(data_sizeN), .data_addr(data_addrN),
        .data_wdata(data_wdataN), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] expSize(input logic [3:0] sw);
        if (sw == 4'hF || sw == 4'h0) return 2'd2;
        if (sw == 4'h3 || sw == 4'hC) return 2'd1;
        if ($countones(sw) == 1) return 2'd0;
        return 2'd2;
    endfunction

    function automatic logic [31:0] expAddr(input logic [31:0] a, input bit doMap);
        if (doMap && (a[31:29] == 3'd4 || a[31:29] == 3'd5)) return {3'b000, a[28:0]};
        return a;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            sig_en = 1'b0;
            longest_stall = 1'b0;
            data_addr_ok = 1'b0;
            data_data_ok = 1'($urandom_range(0, 1));
            data_rdata = $urandom;
            #4;
            chk("idle_stall", 32'(d_stall), 32'd0);
            chk("idle_req", 32'(data_req), 32'd0);
            chk("idle_rdata", rdata, expRdata);
        end
    endtask

    // One core access: addrDelay REQ cycles before addr_ok, then either same-cycle data_ok
    // or dataDelay WAIT cycles before data_ok, then hold cycles of longest_stall in DONE.
    task automatic doAccess(input logic [3:0] sw, input logic [31:0] a, input logic [31:0] wd,
                            input int addrDelay, input bit sameCycle, input int dataDelay,
                            input logic [31:0] rd, input int hold);
        logic [31:0] ea, eaN;
        logic [1:0]  es;
        ea  = expAddr(a, 1'b1);
        eaN = expAddr(a, 1'b0);
        es  = expSize(sw);

        nextCycle();
        sig_en = 1'b1; sig_write = sw; addr = a; wdata = wd;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; longest_stall = 1'b1; data_rdata = $urandom;
        #4;
        chk("start_stall", 32'(d_stall), 32'd1);
        chk("start_req", 32'(data_req), 32'd0);

        for (int k = 0; k <= addrDelay; k++) begin
            nextCycle();
            data_addr_ok = (k == addrDelay);
            data_data_ok = (k == addrDelay) && sameCycle;
            data_rdata = data_data_ok ? rd : $urandom;
            #4;
            chk("req_req", 32'(data_req), 32'd1);
            chk("req_stall", 32'(d_stall), 32'd1);
            chk("req_wr", 32'(data_wr), 32'(sw != 4'h0));
            chk("req_size", 32'(data_size), 32'(es));
            chk("req_addr", data_addr, ea);
            chk("req_addr_nomap", data_addrN, eaN);
            chk("req_size_nomap", 32'(data_sizeN), 32'(es));
            chk("req_wdata", data_wdata, wd);
            chk("req_rdata_hold", rdata, expRdata);
        end

        if (!sameCycle) begin
            for (int k = 0; k <= dataDelay; k++) begin
                nextCycle();
                data_addr_ok = 1'b0;
                data_data_ok = (k == dataDelay);
                data_rdata = data_data_ok ? rd : $urandom;
                #4;
                chk("wait_req", 32'(data_req), 32'd0);
                chk("wait_stall", 32'(d_stall), 32'd1);
                chk("wait_rdata_hold", rdata, expRdata);
            end
        end

        if (sw == 4'h0) expRdata = rd;

        for (int h = 0; h <= hold; h++) begin
            nextCycle();
            data_addr_ok = 1'b0;
            data_data_ok = 1'($urandom_range(0, 1));
            data_rdata = $urandom;
            longest_stall = (h < hold);
            #4;
            chk("done_stall", 32'(d_stall), 32'd0);
            chk("done_req", 32'(data_req), 32'd0);
            chk("done_rdata", rdata, expRdata);
            chk("done_rdata_nomap", rdataN, expRdata);
        end
    endtask

    logic [3:0]  swTab [10] = '{4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'h7};
    logic [2:0]  hiTab [6]  = '{3'b100, 3'b101, 3'b000, 3'b110, 3'b111, 3'b001};

    initial begin
        logic [31:0] r;
        rst = 1'b1; sig_en = 1'b0; sig_write = 4'h0; addr = 32'd0; wdata = 32'd0;
        longest_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        nextCycle();
        nextCycle();
        #4;
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_req", 32'(data_req), 32'd0);
        chk("reset_wr", 32'(data_wr), 32'd0);
        chk("reset_size", 32'(data_size), 32'd0);
        chk("reset_addr", data_addr, 32'd0);
        chk("reset_wdata", data_wdata, 32'd0);
        chk("reset_stall", 32'(d_stall), 32'd0);
        nextCycle();
        rst = 1'b0;

        // zero-wait read in kseg1
        doAccess(4'h0, 32'hBFC0_0010, 32'h0, 0, 1'b0, 0, 32'h1234_5678, 0);
        idleCycles(1);
        // byte write with a slow addr_ok
        doAccess(4'b0100, 32'h8000_0002, 32'h00AB_0000, 3, 1'b0, 0, 32'hFFFF_FFFF, 0);
        idleCycles(1);
        // read completes while the pipeline stays frozen, then back-to-back access
        doAccess(4'h0, 32'h0000_1000, 32'h0, 1, 1'b0, 2, 32'h0BAD_F00D, 5);
        // addr_ok and data_ok together
        doAccess(4'h0, 32'h8000_0040, 32'h0, 0, 1'b1, 0, 32'hDEAD_BEEF, 0);
        // unmapped kseg1 address and a halfword write
        doAccess(4'h0, 32'hA000_0000, 32'h0, 0, 1'b0, 1, 32'h5555_AAAA, 1);
        doAccess(4'b0011, 32'hA000_0004, 32'h0000_BEEF, 1, 1'b1, 0, 32'h0, 0);
        idleCycles(2);

        // reset while waiting for data_ok
        nextCycle();
        sig_en = 1'b1; sig_write = 4'h0; addr = 32'h8000_0100; longest_stall = 1'b1;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        nextCycle();
        data_addr_ok = 1'b1;
        nextCycle();
        data_addr_ok = 1'b0;
        #4;
        chk("rst_pre_wait_stall", 32'(d_stall), 32'd1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0; sig_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hAAAA_5555;
        #4;
        expRdata = 32'd0;
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_stall", 32'(d_stall), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        nextCycle();
        data_data_ok = 1'b0;
        #4;
        chk("late_ok_rdata", rdata, 32'd0);
        chk("late_ok_req", 32'(data_req), 32'd0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            doAccess(swTab[$urandom_range(0, 9)], {hiTab[$urandom_range(0, 5)], r[28:0]}, $urandom,
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     $urandom, $urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
